mem_write_seq: RTL and testbench
================================

MEM_WRITE_SEQ -- requirements
Module: mem_write_seq

Interface
REQ-001 SHALL have parameter: WORD_W, default 16, width of one memory word.
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: start  input  1  request to write one 4-word line.
REQ-005 SHALL have port: addr  input  16  line byte address; bits [2:0] ignored.
REQ-006 SHALL have port: data_in  input  4*WORD_W  line data; word k = data_in[k*WORD_W +: WORD_W].
REQ-007 SHALL have port: stall  input  1  memory not ready; current beat held.
REQ-008 SHALL have port: wr  output  1  write strobe for current beat.
REQ-009 SHALL have port: index  output  2  current beat number, 0..3.
REQ-010 SHALL have port: mem_addr  output  16  beat byte address.
REQ-011 SHALL have port: mem_data  output  WORD_W  beat write data.
REQ-012 SHALL have port: busy  output  1  sequencer occupied.
REQ-013 SHALL have port: done  output  1  one-cycle pulse, line complete.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, WRITE, DONE.
REQ-015 In IDLE with start=1, SHALL capture addr[15:3] and all of data_in, clear beat counter to 0, and enter WRITE next cycle.
REQ-016 In IDLE with start=0, SHALL stay in IDLE with wr=0, busy=0, done=0.
REQ-017 In WRITE, SHALL drive wr=1, busy=1, index=beat, mem_addr={addr_q[15:3], beat, 1'b0}, mem_data=captured word[beat].
REQ-018 In WRITE, a beat with stall=0 SHALL be accepted; beat increments by 1 next cycle.
REQ-019 Acceptance of beat 3 SHALL move the FSM to DONE; beat counter does not wrap into a fifth write.
REQ-020 In DONE, SHALL drive done=1, busy=0, wr=0 for exactly one cycle, then return to IDLE.
REQ-021 Latency with stall held 0: start sampled at edge N; beats at cycles N+1..N+4; done at N+5.
REQ-022 start in WRITE or DONE SHALL be ignored; captured address/data SHALL not change until the next IDLE acceptance.
REQ-023 addr/data_in changes after capture SHALL not affect outputs of an in-progress line.
REQ-024 Outside WRITE, index, mem_addr, mem_data SHALL be 0.

Reset
REQ-025 rst=1 SHALL force, asynchronously: state=IDLE, beat=0, wr=0, busy=0, done=0, index=0, mem_addr=0, mem_data=0.
REQ-026 rst asserted mid-line SHALL abandon the line: no further beats, no done pulse.
REQ-027 First start accepted at the first rising edge after rst deasserts.

Configuration
REQ-028 Macro MEM_WRITE_STALL_EN SHALL select stall support.
REQ-029 With MEM_WRITE_STALL_EN defined: stall=1 in WRITE holds beat, wr, index, mem_addr, mem_data unchanged; stall in IDLE/DONE has no effect.
REQ-030 Without MEM_WRITE_STALL_EN: stall input SHALL be present but ignored; every WRITE cycle accepts a beat (fixed 4-cycle line).

Verification
REQ-031 Reset then start=1, addr=0x1238, data_in={0xDDDD,0xCCCC,0xBBBB,0xAAAA}, stall=0 -> beats index 0..3, mem_addr 0x1238,0x123A,0x123C,0x123E, mem_data 0xAAAA,0xBBBB,0xCCCC,0xDDDD; done=1 at N+5 only.
REQ-032 (STALL_EN) same line, stall=1 during beat 1 for 3 cycles -> index=1, mem_addr=0x123A, wr=1 held 4 cycles total; done at N+8.
REQ-033 start=1 re-asserted during beats with addr=0xFFF8 -> ignored; mem_addr stays in 0x1238..0x123E; single done pulse.
REQ-034 rst pulsed during beat 2 -> wr, busy, index drop to 0 immediately; no done; next start runs a clean 4-beat line.
REQ-035 Back-to-back: start held 1 continuously -> second line begins the cycle after done (IDLE acceptance), busy=0 for exactly the done cycle and one IDLE cycle.
REQ-036 (no STALL_EN) stall=1 throughout -> 4 beats in cycles N+1..N+4, done at N+5.

Source files
------------

// File: rtl/mem_write_seq.sv
// mem_write_seq: writes one captured 4-word line to memory as four sequential beats.
// Latency: start sampled at edge N -> beats in the four cycles after edges N..N+3, done pulse after edge N+4.
// Backpressure: with MEM_WRITE_STALL_EN defined, stall=1 holds the current beat; otherwise stall is ignored.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   start     request to write one line (honoured only in IDLE)
//   addr      line byte address, bits [2:0] ignored
//   data_in   line data, word k = data_in[k*WORD_W +: WORD_W]
//   stall     memory not ready (used only when MEM_WRITE_STALL_EN is defined)
//   wr        write strobe for the current beat
//   index     current beat number 0..3
//   mem_addr  beat byte address {line, beat, 1'b0}
//   mem_data  beat write data
//   busy      sequencer is writing a line
//   done      one-cycle pulse after the last beat is accepted
//
// Configuration macro: MEM_WRITE_STALL_EN (stall support).

module mem_write_seq #(
    parameter int WORD_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [15:0]         addr,
    input  logic [4*WORD_W-1:0] data_in,
    input  logic                stall,
    output logic                wr,
    output logic [1:0]          index,
    output logic [15:0]         mem_addr,
    output logic [WORD_W-1:0]   mem_data,
    output logic                busy,
    output logic                done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [1:0]               beat_q, beat_d;
    logic [12:0]              line_q, line_d;
    logic [3:0][WORD_W-1:0]   data_q, data_d;
    logic                     beat_accept;

`ifdef MEM_WRITE_STALL_EN
    // Memory accepts the current beat only when it is not stalling.
    assign beat_accept = ~stall;

    // Byte offset within the line is never used: beats are word aligned.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr[2:0];
`else
    // Fixed-rate line: every WRITE cycle retires a beat, stall is tied off.
    assign beat_accept = 1'b1;

    logic unused_inputs;
    assign unused_inputs = ^{addr[2:0], stall};
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            beat_q  <= 2'd0;
            line_q  <= 13'd0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            line_q  <= line_d;
            data_q  <= data_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        line_d  = line_q;
        data_d  = data_q;

        case (state_q)
            S_IDLE: begin
                // Capture happens only here, so later addr/data_in changes
                // and start pulses during a line cannot disturb it.
                if (start) begin
                    state_d = S_WRITE;
                    beat_d  = 2'd0;
                    line_d  = addr[15:3];
                    data_d  = data_in;
                end
            end

            S_WRITE: begin
                if (beat_accept) begin
                    if (beat_q == 2'd3) begin
                        // Last beat retired: leave WRITE rather than wrapping
                        // the counter into a fifth write.
                        state_d = S_DONE;
                        beat_d  = 2'd0;
                    end else begin
                        beat_d  = beat_q + 2'd1;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
                beat_d  = 2'd0;
            end

            default: begin
                state_d = S_IDLE;
                beat_d  = 2'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic (Moore): all beat outputs are zero outside WRITE, and
    // because they decode only registered state, reset clears them at once.
    // ------------------------------------------------------------------
    always_comb begin
        wr       = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        index    = 2'd0;
        mem_addr = 16'd0;
        mem_data = '0;

        case (state_q)
            S_WRITE: begin
                wr       = 1'b1;
                busy     = 1'b1;
                index    = beat_q;
                mem_addr = {line_q, beat_q, 1'b0};
                mem_data = data_q[beat_q];
            end

            S_DONE: begin
                done     = 1'b1;
            end

            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mem_write_seq.sv
// Testbench for mem_write_seq: directed stimulus with a cycle-tagged scoreboard.
// Every sampled cycle compares wr/busy/done/index/mem_addr/mem_data against queued expectations.
// Cycle label c = number of the rising edge just passed; outputs are sampled 1 time unit after it.

module tb_mem_write_seq;

    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [15:0]    addr;
    logic [4*W-1:0] data_in;
    logic           stall;
    logic           wr;
    logic [1:0]     index;
    logic [15:0]    mem_addr;
    logic [W-1:0]   mem_data;
    logic           busy;
    logic           done;

    mem_write_seq #(.WORD_W(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .addr     (addr),
        .data_in  (data_in),
        .stall    (stall),
        .wr       (wr),
        .index    (index),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [15:0] addr;
        logic [15:0] data;
        logic [1:0]  idx;
    } beat_t;

    beat_t beat_q[$];
    int    done_q[$];
    int    cyc   = 0;
    int    tests = 0;
    int    fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push_beat(input int c, input logic [15:0] a, input logic [4*W-1:0] d, input int k);
        beat_t    b;
        logic [1:0] kk;
        kk     = 2'(k);
        b.cyc  = c;
        b.addr = {a[15:3], kk, 1'b0};
        b.data = d[k*W +: W];
        b.idx  = kk;
        beat_q.push_back(b);
    endtask

    // Unstalled line accepted at edge n: beat k at cycle n+k, done at n+4.
    task automatic queue_line(input int n, input logic [15:0] a, input logic [4*W-1:0] d);
        for (int k = 0; k < 4; k++) push_beat(n + k, a, d, k);
        done_q.push_back(n + 4);
    endtask

    task automatic check_cycle();
        logic  exp_wr;
        logic  exp_done;
        beat_t b;
        exp_wr   = (beat_q.size() > 0) && (beat_q[0].cyc == cyc);
        exp_done = (done_q.size() > 0) && (done_q[0] == cyc);
        chk("wr", 32'(wr), 32'(exp_wr));
        chk("busy", 32'(busy), 32'(exp_wr));
        chk("done", 32'(done), 32'(exp_done));
        if (exp_wr) begin
            b = beat_q.pop_front();
            chk("index", 32'(index), 32'(b.idx));
            chk("mem_addr", 32'(mem_addr), 32'(b.addr));
            chk("mem_data", 32'(mem_data), 32'(b.data));
        end else begin
            chk("index_idle", 32'(index), 32'd0);
            chk("mem_addr_idle", 32'(mem_addr), 32'd0);
            chk("mem_data_idle", 32'(mem_data), 32'd0);
        end
        if (exp_done) void'(done_q.pop_front());
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            check_cycle();
        end
    endtask

    task automatic drain(input string tag);
        chk({tag, "_beats_left"}, 32'(beat_q.size()), 32'd0);
        chk({tag, "_done_left"}, 32'(done_q.size()), 32'd0);
        beat_q.delete();
        done_q.delete();
    endtask

    localparam logic [15:0]    A0 = 16'h1238;
    localparam logic [4*W-1:0] D0 = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA};

    int n;

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        addr    = 16'h0;
        data_in = '0;
        stall   = 1'b0;

        // Reset state before any clock edge.
        #3;
        chk("rst_wr", 32'(wr), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_index", 32'(index), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_data", 32'(mem_data), 32'd0);
        step(2);

        // Basic line; start accepted at the first edge after reset release.
        rst     = 1'b0;
        start   = 1'b1;
        addr    = A0;
        data_in = D0;
        n = cyc + 1;
        queue_line(n, A0, D0);
        step();
        start = 1'b0;
        step(6);
        drain("basic");

        // start and new addr/data during the line are ignored.
        start   = 1'b1;
        addr    = A0;
        data_in = D0;
        n = cyc + 1;
        queue_line(n, A0, D0);
        step();
        addr    = 16'hFFF8;
        data_in = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        step(2);
        start = 1'b0;
        step(5);
        drain("restart_ignored");

`ifdef MEM_WRITE_STALL_EN
        // Stall beat 1 for three extra cycles: beat 1 visible four cycles.
        start   = 1'b1;
        addr    = A0;
        data_in = D0;
        n = cyc + 1;
        push_beat(n, A0, D0, 0);
        for (int i = 1; i <= 4; i++) push_beat(n + i, A0, D0, 1);
        push_beat(n + 5, A0, D0, 2);
        push_beat(n + 6, A0, D0, 3);
        done_q.push_back(n + 7);
        step();
        start = 1'b0;
        step();
        stall = 1'b1;
        step(3);
        stall = 1'b0;
        step(5);
        drain("stall_beat1");
`else
        // stall has no effect: fixed four-beat line.
        stall   = 1'b1;
        start   = 1'b1;
        addr    = A0;
        data_in = D0;
        n = cyc + 1;
        queue_line(n, A0, D0);
        step();
        start = 1'b0;
        step(6);
        stall = 1'b0;
        drain("stall_ignored");
`endif

        // Reset during beat 2 abandons the line immediately.
        start   = 1'b1;
        addr    = A0;
        data_in = D0;
        n = cyc + 1;
        queue_line(n, A0, D0);
        step();
        start = 1'b0;
        step(2);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_wr", 32'(wr), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_index", 32'(index), 32'd0);
        chk("async_rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("async_rst_mem_data", 32'(mem_data), 32'd0);
        beat_q.delete();
        done_q.delete();
        step();
        rst = 1'b0;
        step(6);
        drain("abandoned");

        // Clean line after reset, low address bits set and ignored.
        start   = 1'b1;
        addr    = 16'hA5F7;
        data_in = 64'h0123_4567_89AB_CDEF;
        n = cyc + 1;
        queue_line(n, 16'hA5F7, 64'h0123_4567_89AB_CDEF);
        step();
        start = 1'b0;
        step(6);
        drain("post_reset");

        // Back-to-back with start held: second line at n+6, busy low at n+4, n+5.
        start   = 1'b1;
        addr    = A0;
        data_in = D0;
        n = cyc + 1;
        queue_line(n, A0, D0);
        queue_line(n + 6, A0, D0);
        step(7);
        start = 1'b0;
        step(6);
        drain("back_to_back");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, observed cycle %0d required < 5000", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
